// File: rtl/axi_line_fetcher.sv
// Reads one text line from an AXI4-Lite slave, one word at a time, and forwards
// each word downstream until a word holding an EOL byte or the word limit is reached.
module axi_line_fetcher #(
   parameter int AXI_DATAW = 32,
   parameter int ADDR_W    = 32,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [CNT_W-1:0]     max_words,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [CNT_W-1:0]     word_cnt,
   output logic [ADDR_W-1:0]    m_araddr,
   output logic                 m_arvalid,
   input  logic                 m_arready,
   input  logic [AXI_DATAW-1:0] m_rdata,
   input  logic [1:0]           m_rresp,
   input  logic                 m_rvalid,
   output logic                 m_rready,
   output logic [AXI_DATAW-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last
);

   localparam int BW = AXI_DATAW / 8;

   function automatic logic has_eol(input logic [AXI_DATAW-1:0] w);
      logic found;
      found = 1'b0;
      for (int b = 0; b < BW; b++) begin
         if (w[8*b +: 8] == 8'h0A) found = 1'b1;
      end
      return found;
   endfunction

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_OUT, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_W-1:0]      base_q, base_d;
   logic [CNT_W-1:0]       max_q, max_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic [AXI_DATAW-1:0]   data_q, data_d;
   logic                   last_q, last_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      data_d  = data_q;
      last_d  = last_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               max_d   = max_words;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = (max_words == '0) ? S_DONE : S_AR;
            end
         end
         S_AR: begin
            if (m_arready) state_d = S_R;
         end
         S_R: begin
            if (m_rvalid) begin
               if (m_rresp != 2'b00) begin
                  // Failed beat is dropped; the run ends with the words already delivered.
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  data_d  = m_rdata;
                  last_d  = has_eol(m_rdata) || ((cnt_q + CNT_W'(1)) == max_q);
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = last_q ? S_DONE : S_AR;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy      = (state_q == S_AR) || (state_q == S_R) || (state_q == S_OUT);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
   assign word_cnt  = cnt_q;
   // Word address derives from the delivered count, so it cannot move while AR waits.
   assign m_araddr  = base_q + ADDR_W'(cnt_q) * ADDR_W'(BW);
   assign m_arvalid = (state_q == S_AR);
   assign m_rready  = (state_q == S_R);
   assign out_valid = (state_q == S_OUT);
   assign out_data  = data_q;
   assign out_last  = last_q;

endmodule

// File: tb/tb_axi_line_fetcher.sv
// Scoreboard bench for axi_line_fetcher: a reactive AXI slave and stream sink,
// a line-level reference model filling expectation queues, and a monitor draining them.
module tb_axi_line_fetcher;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] max_words = '0;
   logic          busy, done, err;
   logic [CW-1:0] word_cnt;
   logic [AW-1:0] m_araddr;
   logic          m_arvalid;
   logic          m_arready = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   logic [1:0]    m_rresp = 2'b00;
   logic          m_rvalid = 1'b0;
   logic          m_rready;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;

   axi_line_fetcher #(.AXI_DATAW(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .max_words(max_words),
      .busy(busy), .done(done), .err(err), .word_cnt(word_cnt),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] d; logic l; } beat_t;
   typedef struct { int n; logic e; } run_t;

   beat_t       exp_out[$];
   logic [31:0] exp_addr[$];
   run_t        exp_run[$];
   logic [31:0] mem [logic [31:0]];
   bit          bad [logic [31:0]];

   int vec = 0;
   int mis = 0;
   int done_cnt = 0;
   int slave_slow = 0;
   int sink_mode = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   function automatic bit eol_in(input logic [31:0] w);
      for (int b = 0; b < 4; b++) if (w[8*b +: 8] == 8'h0A) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] gen_word(input bit put_eol);
      logic [31:0] w;
      logic [7:0]  x;
      int          lane;
      for (int b = 0; b < 4; b++) begin
         x = 8'($urandom_range(0, 255));
         if (x == 8'h0A) x = 8'h0B;
         w[8*b +: 8] = x;
      end
      if (put_eol) begin
         lane = $urandom_range(0, 3);
         w[8*lane +: 8] = 8'h0A;
      end
      return w;
   endfunction

   task automatic fill(input logic [31:0] base, input int n, input int eol_at, input int bad_at);
      logic [31:0] a;
      mem.delete();
      bad.delete();
      for (int i = 0; i < n; i++) begin
         a = base + 32'(i) * 32'd4;
         mem[a] = gen_word(i == eol_at);
         if (i == bad_at) bad[a] = 1'b1;
      end
   endtask

   // Line-level model: walk words from base until EOL, limit, or a failed read.
   task automatic plan(input logic [31:0] base, input int maxw);
      logic [31:0] a, w;
      beat_t       bt;
      run_t        r;
      r.n = 0;
      r.e = 1'b0;
      for (int i = 0; i < maxw; i++) begin
         a = base + 32'(i) * 32'd4;
         exp_addr.push_back(a);
         if (bad.exists(a)) begin
            r.e = 1'b1;
            break;
         end
         w = mem.exists(a) ? mem[a] : 32'h0;
         bt.d = w;
         bt.l = eol_in(w) || (i + 1 == maxw);
         exp_out.push_back(bt);
         r.n++;
         if (bt.l) break;
      end
      exp_run.push_back(r);
   endtask

   task automatic flush();
      exp_out.delete();
      exp_addr.delete();
      exp_run.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'(0));
      chk({tag, "_done"}, 64'(done), 64'(0));
      chk({tag, "_err"}, 64'(err), 64'(0));
      chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(0));
      chk({tag, "_araddr"}, 64'(m_araddr), 64'(0));
      chk({tag, "_arvalid"}, 64'(m_arvalid), 64'(0));
      chk({tag, "_rready"}, 64'(m_rready), 64'(0));
      chk({tag, "_out_data"}, 64'(out_data), 64'(0));
      chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      chk({tag, "_out_last"}, 64'(out_last), 64'(0));
   endtask

   task automatic run(input logic [31:0] base, input int maxw, input bit poke);
      int d0;
      int budget;
      plan(base, maxw);
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = base;
      max_words = CW'(maxw);
      @(posedge clk); #1;
      start = 1'b0;
      base_addr = $urandom;
      max_words = CW'($urandom);
      chk("arvalid_after_start", 64'(m_arvalid), 64'(maxw != 0));
      chk("done_after_start", 64'(done), 64'(maxw == 0));
      chk("busy_after_start", 64'(busy), 64'(maxw != 0));
      chk("err_cleared_by_start", 64'(err), 64'(0));
      chk("cnt_cleared_by_start", 64'(word_cnt), 64'(0));
      if (poke && maxw != 0) begin
         @(posedge clk); #1;
         start = 1'b1;
         base_addr = 32'hDEAD_0000;
         max_words = CW'(1);
         @(posedge clk); #1;
         start = 1'b0;
      end
      budget = maxw * 60 + 40;
      for (int c = 0; c < budget && done_cnt == d0; c++) @(posedge clk);
      #1;
      chk("run_completed", 64'(done_cnt != d0), 64'(1));
      if (done_cnt == d0) flush();
      chk("done_single_cycle", 64'(done), 64'(0));
   endtask

   // AXI slave: random or zero-wait AR acceptance and R latency.
   initial begin
      logic        arhs, rhs, pending;
      logic [31:0] a, paddr;
      int          rwait;
      pending = 1'b0;
      paddr = '0;
      rwait = 0;
      forever begin
         @(negedge clk);
         arhs = !rst && m_arvalid && m_arready;
         rhs  = !rst && m_rvalid && m_rready;
         a    = m_araddr;
         @(posedge clk); #1;
         if (rst) begin
            m_arready = 1'b0;
            m_rvalid  = 1'b0;
            pending   = 1'b0;
            continue;
         end
         if (rhs) m_rvalid = 1'b0;
         if (arhs) begin
            pending = 1'b1;
            paddr   = a;
            rwait   = slave_slow != 0 ? $urandom_range(0, 4) : 0;
         end
         if (pending && !m_rvalid) begin
            if (rwait == 0) begin
               m_rvalid = 1'b1;
               m_rdata  = mem.exists(paddr) ? mem[paddr] : 32'h0;
               m_rresp  = bad.exists(paddr) ? 2'b10 : 2'b00;
               pending  = 1'b0;
            end else begin
               rwait--;
            end
         end
         m_arready = slave_slow != 0 ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
   end

   // Stream sink: always ready, random, or 5-cycle stall on every beat.
   initial begin
      int hold;
      hold = 0;
      forever begin
         @(posedge clk); #1;
         case (sink_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
               if (out_valid) begin
                  if (hold < 5) begin
                     out_ready = 1'b0;
                     hold++;
                  end else begin
                     out_ready = 1'b1;
                  end
               end else begin
                  out_ready = 1'b0;
                  hold = 0;
               end
            end
         endcase
      end
   end

   logic        pa_wait = 1'b0;
   logic        po_wait = 1'b0;
   logic [31:0] pa = '0;
   logic [31:0] pd = '0;
   logic        pl = 1'b0;

   // Monitor: stability of held signals, AR addresses, stream beats, run results.
   initial begin
      beat_t bt;
      run_t  r;
      forever begin
         @(negedge clk);
         if (rst) begin
            pa_wait = 1'b0;
            po_wait = 1'b0;
            continue;
         end
         if (pa_wait) begin
            chk("ar_hold_valid", 64'(m_arvalid), 64'(1));
            chk("ar_hold_addr", 64'(m_araddr), 64'(pa));
         end
         if (po_wait) begin
            chk("out_hold_valid", 64'(out_valid), 64'(1));
            chk("out_hold_data", 64'(out_data), 64'(pd));
            chk("out_hold_last", 64'(out_last), 64'(pl));
         end
         if (out_valid) chk("no_ar_during_out", 64'(m_arvalid), 64'(0));
         if (m_arvalid && m_arready) begin
            if (exp_addr.size() == 0) begin
               vec++;
               mis++;
               $display("FAIL unexpected_ar: got addr %0h, required no read", m_araddr);
            end else begin
               chk("araddr", 64'(m_araddr), 64'(exp_addr.pop_front()));
            end
         end
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
               vec++;
               mis++;
               $display("FAIL unexpected_beat: got %0h, required no beat", out_data);
            end else begin
               bt = exp_out.pop_front();
               chk("out_data", 64'(out_data), 64'(bt.d));
               chk("out_last", 64'(out_last), 64'(bt.l));
            end
         end
         if (done) begin
            if (exp_run.size() == 0) begin
               vec++;
               mis++;
               $display("FAIL unexpected_done: got done, required none");
            end else begin
               r = exp_run.pop_front();
               chk("word_cnt", 64'(word_cnt), 64'(r.n));
               chk("err", 64'(err), 64'(r.e));
               chk("beats_left", 64'(exp_out.size()), 64'(0));
               chk("ars_left", 64'(exp_addr.size()), 64'(0));
            end
            done_cnt++;
         end
         pa_wait = m_arvalid && !m_arready;
         pa      = m_araddr;
         po_wait = out_valid && !out_ready;
         pd      = out_data;
         pl      = out_last;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] base;
      int          maxw, eol_at, bad_at, cyc;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      // Two-word line ending on an EOL in the top byte.
      slave_slow = 0;
      sink_mode = 0;
      mem.delete();
      bad.delete();
      mem[32'h100] = 32'h4142_4344;
      mem[32'h104] = 32'h0A45_4647;
      run(32'h100, 8, 1'b0);
      chk("t1_word_cnt_hold", 64'(word_cnt), 64'(2));
      chk("t1_err_hold", 64'(err), 64'(0));

      fill(32'h0, 3, -1, -1);
      run(32'h0, 3, 1'b0);
      chk("t2_word_cnt_hold", 64'(word_cnt), 64'(3));

      run(32'h40, 0, 1'b0);
      chk("t3_word_cnt", 64'(word_cnt), 64'(0));

      fill(32'h200, 4, -1, 1);
      run(32'h200, 4, 1'b0);
      chk("t4_err_hold", 64'(err), 64'(1));
      fill(32'h300, 2, -1, -1);
      run(32'h300, 2, 1'b0);

      slave_slow = 1;
      sink_mode = 2;
      fill(32'h400, 5, -1, -1);
      run(32'h400, 5, 1'b1);

      // Reset while waiting for read data.
      sink_mode = 1;
      fill(32'h500, 4, -1, -1);
      plan(32'h500, 4);
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = 32'h500;
      max_words = CW'(4);
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!m_rready && cyc < 100);
      chk("t6_reached_r", 64'(m_rready), 64'(1));
      rst = 1'b1;
      #1;
      chk_zero("midrun_reset");
      flush();
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      fill(32'h600, 3, 1, -1);
      run(32'h600, 3, 1'b0);

      for (int it = 0; it < 20; it++) begin
         slave_slow = $urandom_range(0, 1);
         sink_mode  = $urandom_range(0, 2);
         base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         maxw   = $urandom_range(1, 6);
         eol_at = $urandom_range(0, 7);
         bad_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, maxw - 1) : -1;
         fill(base, maxw, eol_at, bad_at);
         run(base, maxw, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
